// File: rtl/packet_framer_if.sv
// Handshake bundle between the packet framer, its payload source and the downstream serializer.
// The framer uses the slave modport; the stimulus/serializer side uses the master modport.
interface packet_framer_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              end_packet;
  logic              done;
  logic              abort;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic [DATA_W-1:0] data_out;
  logic              data_req;
  logic              busy;
  logic              pkt_done;
  logic [LEN_W-1:0]  word_cnt;

  modport master (
    output start, len, end_packet, done, abort, data_in,
    input  load, data_out, data_req, busy, pkt_done, word_cnt
  );

  modport slave (
    input  start, len, end_packet, done, abort, data_in,
    output load, data_out, data_req, busy, pkt_done, word_cnt
  );
endinterface

// File: rtl/packet_framer.sv
// Packet framing controller: SOF, up to MAX_LEN payload words, optional XOR checksum, EOF,
// each word pushed with a one-cycle load and held until the serializer reports done.
module packet_framer #(
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] SOF_WORD = DATA_W'(8'hAA),
  parameter logic [DATA_W-1:0] EOF_WORD = DATA_W'(8'hBB),
  parameter int              MAX_LEN  = 16,
  parameter bit              CHK_EN   = 1'b1,
  parameter int              LEN_W    = $clog2(MAX_LEN + 1)
) (
  input logic          clk,
  input logic          rst,
  packet_framer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    SOF_LOAD,
    SOF_SEND,
    DATA_LOAD,
    DATA_SEND,
    CHK_LOAD,
    CHK_SEND,
    EOF_LOAD,
    EOF_SEND
  } state_t;

  localparam state_t           TAIL  = CHK_EN ? CHK_LOAD : EOF_LOAD;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] chk_q;
  logic              pkt_done_q;
  logic [LEN_W-1:0]  len_clamped;

  assign len_clamped = (bus.len > MAX_L) ? MAX_L : bus.len;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment at the top keeps this block purely combinational (no latch).
  always_comb begin
    state_d = state_q;
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (bus.start) state_d = SOF_LOAD;
        SOF_LOAD:  state_d = SOF_SEND;
        SOF_SEND:  if (bus.done) state_d = (len_q != '0) ? DATA_LOAD : TAIL;
        DATA_LOAD: state_d = DATA_SEND;
        DATA_SEND: if (bus.done) state_d = (bus.end_packet || cnt_q == len_q) ? TAIL : DATA_LOAD;
        CHK_LOAD:  state_d = CHK_SEND;
        CHK_SEND:  if (bus.done) state_d = EOF_LOAD;
        EOF_LOAD:  state_d = EOF_SEND;
        EOF_SEND:  if (bus.done) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Length, payload counter and running checksum; the counter keeps its value after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
      chk_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      len_q <= len_clamped;
      cnt_q <= '0;
      chk_q <= '0;
    end else if (state_q == DATA_LOAD) begin
      cnt_q <= cnt_q + LEN_W'(1);
      chk_q <= chk_q ^ bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_done_q <= 1'b0;
    else     pkt_done_q <= (state_q == EOF_SEND) && bus.done && !bus.abort;
  end

  // Outputs are forced low while rst is high so nothing leaks out during a mid-packet reset.
  always_comb begin
    bus.load     = 1'b0;
    bus.data_out = '0;
    bus.data_req = 1'b0;
    bus.busy     = 1'b0;
    bus.pkt_done = 1'b0;
    bus.word_cnt = '0;
    if (!rst) begin
      bus.busy     = (state_q != IDLE);
      bus.pkt_done = pkt_done_q;
      bus.word_cnt = cnt_q;
      unique case (state_q)
        SOF_LOAD: begin
          bus.load     = 1'b1;
          bus.data_out = SOF_WORD;
        end
        DATA_LOAD: begin
          bus.load     = 1'b1;
          bus.data_out = bus.data_in;
          bus.data_req = 1'b1;
        end
        CHK_LOAD: begin
          bus.load     = 1'b1;
          bus.data_out = chk_q;
        end
        EOF_LOAD: begin
          bus.load     = 1'b1;
          bus.data_out = EOF_WORD;
        end
        default: ;
      endcase
    end
  end

endmodule
